// File: rtl/md_unit_pkg.sv
// Shared MD opcode encoding and the combinational multiply/divide datapath
// used by the E-stage multiply/divide unit.
package md_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef struct packed {
        logic        commit;
        logic [31:0] hi;
        logic [31:0] lo;
    } md_res_t;

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic md_res_t md_compute(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        md_res_t            r;
        logic [63:0]        p;
        logic [31:0]        bs;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        r  = '0;
        p  = '0;
        // Divisor forced to 1 on zero so the datapath never produces X; commit is dropped.
        bs = (b == 32'd0) ? 32'd1 : b;
        sa = a;
        sb = bs;
        case (op)
            MD_MULT: begin
                // Low 64 bits of the sign-extended product equal the signed 32x32 product.
                p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                r = '{commit: 1'b1, hi: p[63:32], lo: p[31:0]};
            end
            MD_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                r = '{commit: 1'b1, hi: p[63:32], lo: p[31:0]};
            end
            MD_DIV: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    r = '{commit: 1'b1, hi: 32'd0, lo: 32'h8000_0000};
                else
                    r = '{commit: (b != 32'd0), hi: sa % sb, lo: sa / sb};
            end
            MD_DIVU: r = '{commit: (b != 32'd0), hi: a % bs, lo: a / bs};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-length busy window,
// result latched at start and committed when the countdown expires.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic        md_start,
    input  logic        flush_E,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        md_busy,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    logic [3:0]  cnt;
    logic [31:0] hi_sh;
    logic [31:0] lo_sh;
    logic        commit_sh;
    logic        idle;
    logic        accept;
    md_res_t     res;

    assign idle    = (cnt == 4'd0);
    assign accept  = md_start & ~flush_E & idle;
    assign res     = md_compute(md_op, rs_val, rt_val);
    assign md_busy = ~idle;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 4'd0;
            hi_sh     <= 32'd0;
            lo_sh     <= 32'd0;
            commit_sh <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
        end else if (accept) begin
            cnt       <= md_is_div(md_op) ? DIV_N : MULT_N;
            hi_sh     <= res.hi;
            lo_sh     <= res.lo;
            commit_sh <= res.commit;
        end else if (!idle) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1 && commit_sh) begin
                hi <= hi_sh;
                lo <= lo_sh;
            end
        end else if (!flush_E) begin
            if (md_op == MD_MTHI) hi <= rs_val;
            if (md_op == MD_MTLO) lo <= rs_val;
        end
    end

    // Reads see the architectural value only; a pending commit is not forwarded.
    always_comb begin
        md_out = 32'd0;
        if (md_op == MD_MFHI) md_out = hi;
        else if (md_op == MD_MFLO) md_out = lo;
    end

endmodule
